line_buf_ctrl: RTL and testbench
================================

# line_buf_ctrl

Single-clock controller that sits directly upstream of the convolution line-buffer FIFO and turns an incoming row-major pixel stream into that FIFO's control and data signals. The FIFO holds one image row:
- each new pixel is written into the slot that held the pixel one row above;
- that pixel is read back in the same pass, so the convolution core sees the current pixel and its vertical neighbour aligned.

The block also owns all pointer rewinds (`wr_clr`/`rd_clr`) at row boundaries and signals frame completion.

## Interface
Parameters:
- `DATA_WIDTH`, 16 — pixel width; matches the FIFO data width.
- `IFM_WIDTH`, 8 — pixels per row; must be ≤ FIFO depth and ≤ 2^`ADD_WIDTH`.
- `NUM_ROWS`, 8 — rows per frame; must be ≥ 2.
- `ADD_WIDTH`, 3 — FIFO pointer width.

Ports:
- `clk1` in 1 — the single clock; drives this block and both FIFO clock inputs.
- `rst_n` in 1 — asynchronous, active-low reset.
- `start` in 1 — one-cycle frame start; ignored unless in IDLE.
- `pix_valid` in 1 — upstream pixel valid.
- `pix_data` in `DATA_WIDTH` — upstream pixel.
- `pix_ready` out 1 — pixel accepted on any edge where `pix_valid && pix_ready`.
- `wr_en`, `wr_inc`, `wr_clr` out 1 — FIFO write controls.
- `rd_en`, `rd_inc`, `rd_clr` out 1 — FIFO read controls.
- `data_in_fifo` out `DATA_WIDTH` — FIFO write data.
- `cur_data` out `DATA_WIDTH` — current pixel, aligned with FIFO `data_out_fifo`.
- `prev_valid` out 1 — `data_out_fifo` and `cur_data` valid this cycle.
- `col_cnt` out `ADD_WIDTH` — column of the next pixel to accept.
- `row_cnt` out 16 — row of the next pixel to accept.
- `busy` out 1 — not IDLE.
- `done` out 1 — one-cycle frame-complete pulse.

## Operation
- States:
  - IDLE (`pix_ready=0`)
  - CLR (1 cycle)
  - FILL (row 0)
  - GAP (2 cycles)
  - STREAM (rows 1..`NUM_ROWS`-1)
  - DRAIN (2 cycles)
- Transitions:
  - IDLE→CLR on `start`.
  - CLR→FILL.
  - In FILL or STREAM, accepting pixel `IFM_WIDTH`-1 of a row that is not the last → GAP.
  - GAP→CLR-pulse cycle, merged into the first cycle of the next row: STREAM asserts `wr_clr=rd_clr=1` and `pix_ready=1` in that cycle.
  - Accepting the last pixel of row `NUM_ROWS`-1 → DRAIN.
  - DRAIN→IDLE, with `done=1` in the final DRAIN cycle.
- Counters:
  - `col_cnt` wraps `IFM_WIDTH`-1→0.
  - `row_cnt` increments on that wrap.
  - Both cleared in CLR.
- Per accepted pixel at edge e0, all outputs are registered:
  - `wr_en=wr_inc=1` for the following cycle.
  - `rd_en=rd_inc=1` for the following cycle, only in STREAM.
  - `data_in_fifo` = pixel during the cycle after `wr_en` (the FIFO registers its write enable once).
  - `cur_data` = pixel during the cycle after `rd_en`.
- `prev_valid` is `rd_en` delayed one cycle.
- The FIFO read of slot c (row r-1) happens one edge before the write of slot c (row r); this ordering is required.
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-frame aborts immediately, with no `done`.
- `pix_valid` low stalls. No output strobes are issued for stall cycles.

## Timing
- Pixel accepted at e0:
  - `wr_en`/`rd_en` high in (e0,e1].
  - FIFO reads at e1.
  - `prev_valid` and `cur_data` high/valid in (e1,e2].
  - FIFO writes at e2.
- Row boundary, last pixel accepted at e0:
  - `pix_ready=0` in (e0,e2].
  - `wr_clr=rd_clr=1` in (e2,e3] together with `pix_ready=1`, so the clear is sampled at e3.
  - This never collides with the last write at e2.
- Throughput: 1 pixel/cycle within a row; 2 idle cycles per row boundary.
- `done` asserts 2 cycles after the final accept.

## Configuration
- `LINE_BUF_CTRL_PAD_EN` defined: top zero padding. In row 0, `prev_valid` is asserted exactly as in STREAM, but `rd_en` stays 0, so `data_out_fifo` reads 0 at that time.
- Not defined: `prev_valid` is never asserted in row 0.

## Test plan
- Reset, then `start` with `IFM_WIDTH`=8, `NUM_ROWS`=3, and pixel = 16·row+col, `pix_valid` held high:
  - 24 `wr_en` pulses.
  - 16 `prev_valid` pulses.
  - Each `prev_valid` has `data_out_fifo` = `cur_data`−16.
  - `done` exactly once.
- Row boundary check: `pix_ready` low for exactly 2 cycles after col 7, and `wr_clr` never coincides with the FIFO's delayed write enable.
- Random `pix_valid` stalls of 0–3 cycles: same data pairs as the first scenario, and no strobes during stalls.
- `start` pulsed mid-frame: ignored, with the counters unchanged.
- `rst_n` low mid-row 1: all outputs 0 asynchronously; a new `start` produces a correct full frame.
- With `LINE_BUF_CTRL_PAD_EN` defined: 24 `prev_valid` pulses; the row-0 ones have `data_out_fifo`=0.

Source files
------------

// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl
// Turns a row-major pixel stream into the control and data signals of the
// single-row convolution line-buffer FIFO. Each pixel is written into the slot
// that held its vertical neighbour, and that slot is read one edge earlier. The
// FIFO output is therefore aligned with cur_data. This block also issues the
// pointer rewinds at frame start and at each row boundary, and it pulses done
// when a frame is complete.
//
// Optional feature: define LINE_BUF_CTRL_PAD_EN for top zero padding.
// prev_valid is then also raised for row 0, while rd_en stays low, so the FIFO
// presents zeros as the row above.
module line_buf_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int IFM_WIDTH  = 8,
  parameter int NUM_ROWS   = 8,
  parameter int ADD_WIDTH  = 3
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  output logic                  wr_en,
  output logic                  wr_inc,
  output logic                  wr_clr,
  output logic                  rd_en,
  output logic                  rd_inc,
  output logic                  rd_clr,
  output logic [DATA_WIDTH-1:0] data_in_fifo,
  output logic [DATA_WIDTH-1:0] cur_data,
  output logic                  prev_valid,
  output logic [ADD_WIDTH-1:0]  col_cnt,
  output logic [15:0]           row_cnt,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_FILL   = 3'd2,
    ST_GAP    = 3'd3,
    ST_STREAM = 3'd4,
    ST_DRAIN  = 3'd5
  } state_t;

  localparam logic [ADD_WIDTH-1:0] COL_LAST = ADD_WIDTH'(IFM_WIDTH - 1);
  localparam logic [ADD_WIDTH-1:0] COL_ZERO = ADD_WIDTH'(0);
  localparam logic [ADD_WIDTH-1:0] COL_ONE  = ADD_WIDTH'(1);
  localparam logic [15:0]          ROW_LAST = 16'(NUM_ROWS - 1);
  localparam logic [15:0]          ROW_ONE  = 16'd1;

  // The last column closes a row. The row counter wraps the column back to 0.
  function automatic logic is_last_col(input logic [ADD_WIDTH-1:0] col);
    return (col == COL_LAST);
  endfunction

  // A row is the final one of the frame when its index is NUM_ROWS-1.
  function automatic logic is_last_row(input logic [15:0] row);
    return (row == ROW_LAST);
  endfunction

  state_t                 state_q, state_d;
  logic [ADD_WIDTH-1:0]   col_q, col_d;
  logic [15:0]            row_q, row_d;
  logic                   phase_q, phase_d;
  logic                   pix_ready_q, pix_ready_d;
  logic                   wr_clr_q, rd_clr_q, clr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   wr_en_q, wr_inc_q, wr_en_d;
  logic                   rd_en_q, rd_inc_q, rd_en_d;
  logic                   vld_q, vld_d;
  logic                   prev_valid_q, prev_valid_d;
  logic [DATA_WIDTH-1:0]  pix_q, pix_d;
  logic [DATA_WIDTH-1:0]  din_q, din_d;
  logic [DATA_WIDTH-1:0]  cur_q, cur_d;
  logic                   acc_s;

  // The handshake uses the registered ready. A pixel is taken only in FILL or STREAM.
  assign acc_s = pix_valid && pix_ready_q;

  // Frame sequencing: next state, counters, ready, pointer rewinds, and done.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    phase_d     = phase_q;
    pix_ready_d = 1'b0;
    clr_d       = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Rewind both pointers during the single CLR cycle.
          state_d = ST_CLR;
          clr_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLR: begin
        col_d       = COL_ZERO;
        row_d       = 16'd0;
        phase_d     = 1'b0;
        state_d     = ST_FILL;
        pix_ready_d = 1'b1;
      end
      ST_FILL, ST_STREAM: begin
        if (acc_s) begin
          if (is_last_col(col_q)) begin
            col_d   = COL_ZERO;
            row_d   = row_q + ROW_ONE;
            phase_d = 1'b0;
            if (is_last_row(row_q)) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            col_d       = col_q + COL_ONE;
            pix_ready_d = 1'b1;
          end
        end else begin
          pix_ready_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          // The first cycle of the new row carries the rewind and accepts a pixel.
          // The last write of the previous row lands on the edge that enters this cycle.
          phase_d     = 1'b0;
          state_d     = ST_STREAM;
          clr_d       = 1'b1;
          pix_ready_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          phase_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        col_d   = COL_ZERO;
        row_d   = 16'd0;
        phase_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Per-pixel strobes: write always, read only where a row above exists.
  always_comb begin
    wr_en_d = acc_s;
    if (state_q == ST_STREAM) begin
      rd_en_d = acc_s;
    end else begin
      rd_en_d = 1'b0;
    end
`ifdef LINE_BUF_CTRL_PAD_EN
    // Row 0 is also paired with a row above, which the FIFO supplies as zeros.
    if ((state_q == ST_STREAM) || (state_q == ST_FILL)) begin
      vld_d = acc_s;
    end else begin
      vld_d = 1'b0;
    end
`else
    vld_d = rd_en_d;
`endif
    prev_valid_d = vld_q;
  end

  // Data pipeline: capture on accept, then present one cycle after each strobe.
  always_comb begin
    if (acc_s) begin
      pix_d = pix_data;
    end else begin
      pix_d = pix_q;
    end
    if (wr_en_q) begin
      din_d = pix_q;
    end else begin
      din_d = din_q;
    end
    if (vld_q) begin
      cur_d = pix_q;
    end else begin
      cur_d = cur_q;
    end
  end

  // Control registers. Reset aborts a frame immediately and emits no done.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      col_q        <= COL_ZERO;
      row_q        <= 16'd0;
      phase_q      <= 1'b0;
      pix_ready_q  <= 1'b0;
      wr_clr_q     <= 1'b0;
      rd_clr_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_inc_q     <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_inc_q     <= 1'b0;
      vld_q        <= 1'b0;
      prev_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      phase_q      <= phase_d;
      pix_ready_q  <= pix_ready_d;
      wr_clr_q     <= clr_d;
      rd_clr_q     <= clr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wr_en_q      <= wr_en_d;
      wr_inc_q     <= wr_en_d;
      rd_en_q      <= rd_en_d;
      rd_inc_q     <= rd_en_d;
      vld_q        <= vld_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  // Data registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pix_q <= {DATA_WIDTH{1'b0}};
      din_q <= {DATA_WIDTH{1'b0}};
      cur_q <= {DATA_WIDTH{1'b0}};
    end else begin
      pix_q <= pix_d;
      din_q <= din_d;
      cur_q <= cur_d;
    end
  end

  assign pix_ready    = pix_ready_q;
  assign wr_en        = wr_en_q;
  assign wr_inc       = wr_inc_q;
  assign wr_clr       = wr_clr_q;
  assign rd_en        = rd_en_q;
  assign rd_inc       = rd_inc_q;
  assign rd_clr       = rd_clr_q;
  assign data_in_fifo = din_q;
  assign cur_data     = cur_q;
  assign prev_valid   = prev_valid_q;
  assign col_cnt      = col_q;
  assign row_cnt      = row_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Bench for line_buf_ctrl with IFM_WIDTH=8 and NUM_ROWS=3. Pixel = 16*row+col.
// A behavioural single-row FIFO sits on the DUT outputs.
module tb_line_buf_ctrl;
  localparam int DW = 16;
  localparam int IW = 8;
  localparam int NR = 3;
  localparam int AW = 3;
  localparam int NPIX = IW * NR;
`ifdef LINE_BUF_CTRL_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int EXP_PV = (PAD != 0) ? NPIX : (NPIX - IW);

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic          pix_ready, wr_en, wr_inc, wr_clr, rd_en, rd_inc, rd_clr;
  logic [DW-1:0] data_in_fifo, cur_data;
  logic          prev_valid, busy, done;
  logic [AW-1:0] col_cnt;
  logic [15:0]   row_cnt;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int pv_cnt = 0;
  int done_cnt = 0;

  line_buf_ctrl #(.DATA_WIDTH(DW), .IFM_WIDTH(IW), .NUM_ROWS(NR), .ADD_WIDTH(AW)) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .wr_en(wr_en), .wr_inc(wr_inc), .wr_clr(wr_clr),
    .rd_en(rd_en), .rd_inc(rd_inc), .rd_clr(rd_clr), .data_in_fifo(data_in_fifo),
    .cur_data(cur_data), .prev_valid(prev_valid), .col_cnt(col_cnt), .row_cnt(row_cnt),
    .busy(busy), .done(done)
  );

  always #5 clk1 = ~clk1;

  // Behavioural line-buffer FIFO: write enable registered once, registered read (0 when idle).
  logic [DW-1:0] mem [8];
  logic [AW-1:0] f_wptr, f_rptr;
  logic          f_we_q, f_winc_q;
  logic [DW-1:0] f_dout;
  always @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      f_wptr <= '0; f_rptr <= '0; f_we_q <= 1'b0; f_winc_q <= 1'b0; f_dout <= '0;
    end else begin
      f_we_q   <= wr_en;
      f_winc_q <= wr_inc;
      if (f_we_q) mem[f_wptr] <= data_in_fifo;
      if (wr_clr) f_wptr <= '0;
      else if (f_winc_q) f_wptr <= f_wptr + 3'd1;
      if (rd_en) f_dout <= mem[f_rptr];
      else f_dout <= '0;
      if (rd_clr) f_rptr <= '0;
      else if (rd_inc) f_rptr <= f_rptr + 3'd1;
    end
  end

  // Expected strobe timeline built from the pixels this bench hands over.
  logic          s1_acc, s1_rd, s1_pv, s2_acc, s2_pv;
  logic [DW-1:0] s1_pix, s2_pix;
  always @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      s1_acc <= 1'b0; s1_rd <= 1'b0; s1_pv <= 1'b0; s1_pix <= '0;
      s2_acc <= 1'b0; s2_pv <= 1'b0; s2_pix <= '0;
    end else begin
      s1_acc <= pix_valid && pix_ready;
      s1_rd  <= pix_valid && pix_ready && (pix_data >= 16'd16);
      s1_pv  <= pix_valid && pix_ready && ((PAD != 0) || (pix_data >= 16'd16));
      s1_pix <= pix_data;
      s2_acc <= s1_acc;
      s2_pv  <= s1_pv;
      s2_pix <= s1_pix;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({pix_ready, wr_en, wr_inc, wr_clr, rd_en, rd_inc, rd_clr,
                              prev_valid, busy, done}), 0);
    chk({tag, "_din"}, 32'(data_in_fifo), 0);
    chk({tag, "_cur"}, 32'(cur_data), 0);
    chk({tag, "_col"}, 32'(col_cnt), 0);
    chk({tag, "_row"}, 32'(row_cnt), 0);
  endtask

  // Advance to the next falling edge and check every per-cycle invariant.
  task automatic tick();
    int exp_dout;
    @(negedge clk1);
    if (rst_n) begin
      chk("wr_en", 32'(wr_en), 32'(s1_acc));
      chk("wr_inc", 32'(wr_inc), 32'(s1_acc));
      chk("rd_en", 32'(rd_en), 32'(s1_rd));
      chk("rd_inc", 32'(rd_inc), 32'(s1_rd));
      chk("rd_clr", 32'(rd_clr), 32'(wr_clr));
      chk("prev_valid", 32'(prev_valid), 32'(s2_pv));
      if (s2_acc) chk("data_in_fifo", 32'(data_in_fifo), 32'(s2_pix));
      if (s2_pv) begin
        exp_dout = (s2_pix >= 16'd16) ? int'(s2_pix) - 16 : 0;
        chk("cur_data", 32'(cur_data), 32'(s2_pix));
        chk("pair_dout", 32'(f_dout), exp_dout);
      end
      if (wr_clr) chk("clr_vs_we", 32'(f_we_q), 0);
      if (wr_en) wr_cnt++;
      if (prev_valid) pv_cnt++;
      if (done) done_cnt++;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    chk("clr_busy", 32'(busy), 1);
    chk("clr_pulse", 32'(wr_clr), 1);
    start = 1'b0;
    tick();
    chk("fill_ready", 32'(pix_ready), 1);
    chk("fill_clr", 32'(wr_clr), 0);
    chk("fill_col", 32'(col_cnt), 0);
    chk("fill_row", 32'(row_cnt), 0);
  endtask

  // Feed pixels idx..NPIX-1, with optional random stalls, a stray start, or an abort.
  task automatic feed(input int max_stall, input int first_idx, input int start_idx,
                      input int abort_idx);
    int idx = first_idx;
    int stall = 0;
    int low_run = 0;
    int budget = 0;
    bit pulsed = 1'b0;
    bit pulse_now;
    bit acc;
    while (idx < NPIX && budget < 600) begin
      chk("col_cnt", 32'(col_cnt), idx % IW);
      chk("row_cnt", 32'(row_cnt), idx / IW);
      if (idx == abort_idx) begin
        pix_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        tick();
        tick();
        rst_n = 1'b1;
        return;
      end
      pulse_now = 1'b0;
      if (stall > 0) begin
        pix_valid = 1'b0;
        stall--;
      end else if (idx == start_idx && !pulsed) begin
        pix_valid = 1'b0;
        start = 1'b1;
        pulsed = 1'b1;
        pulse_now = 1'b1;
      end else begin
        pix_valid = 1'b1;
        pix_data = 16'((idx / IW) * 16 + (idx % IW));
        if (max_stall > 0) stall = int'($urandom_range(max_stall, 0));
      end
      acc = pix_valid && pix_ready;
      if (!pix_ready) low_run++;
      else begin
        if (low_run > 0) chk("gap_len", low_run, 2);
        low_run = 0;
      end
      tick();
      start = 1'b0;
      if (pulse_now) begin
        chk("midstart_clr", 32'(wr_clr), 0);
        chk("midstart_busy", 32'(busy), 1);
      end
      if (acc) idx++;
      budget++;
    end
    pix_valid = 1'b0;
    if (budget >= 600) chk("feed_timeout", budget, 0);
  endtask

  // The final accept has just happened: done must follow in the second drain cycle.
  task automatic drain_check();
    chk("drain0_done", 32'(done), 0);
    chk("drain0_busy", 32'(busy), 1);
    chk("drain0_ready", 32'(pix_ready), 0);
    tick();
    chk("drain1_done", 32'(done), 1);
    chk("drain1_busy", 32'(busy), 1);
    tick();
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("end_col", 32'(col_cnt), 0);
    chk("end_row", 32'(row_cnt), NR);
  endtask

  typedef struct {
    int st, vl, dat, pr, wr, rd, clr, bsy, col, row, dn;
  } vec_t;

  initial begin
    vec_t tv[16];
    int b_wr, b_pv, b_dn;
    //         st vl dat    pr wr rd clr bsy col row dn
    tv[0]  = '{0, 0, 0,     0, 0, 0, 0,  0,  0,  0,  0};
    tv[1]  = '{1, 0, 0,     0, 0, 0, 1,  1,  0,  0,  0};
    tv[2]  = '{0, 0, 0,     1, 0, 0, 0,  1,  0,  0,  0};
    tv[3]  = '{0, 1, 'h00,  1, 1, 0, 0,  1,  1,  0,  0};
    tv[4]  = '{0, 0, 'h00,  1, 0, 0, 0,  1,  1,  0,  0};
    tv[5]  = '{1, 1, 'h01,  1, 1, 0, 0,  1,  2,  0,  0};
    tv[6]  = '{0, 1, 'h02,  1, 1, 0, 0,  1,  3,  0,  0};
    tv[7]  = '{0, 1, 'h03,  1, 1, 0, 0,  1,  4,  0,  0};
    tv[8]  = '{0, 1, 'h04,  1, 1, 0, 0,  1,  5,  0,  0};
    tv[9]  = '{0, 1, 'h05,  1, 1, 0, 0,  1,  6,  0,  0};
    tv[10] = '{0, 1, 'h06,  1, 1, 0, 0,  1,  7,  0,  0};
    tv[11] = '{0, 1, 'h07,  0, 1, 0, 0,  1,  0,  1,  0};
    tv[12] = '{0, 1, 'h10,  0, 0, 0, 0,  1,  0,  1,  0};
    tv[13] = '{0, 1, 'h10,  1, 0, 0, 1,  1,  0,  1,  0};
    tv[14] = '{0, 1, 'h10,  1, 1, 1, 0,  1,  1,  1,  0};
    tv[15] = '{0, 1, 'h11,  1, 1, 1, 0,  1,  2,  1,  0};

    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Frame A: vector table through the first row boundary, then the rest of the frame.
    b_wr = wr_cnt; b_pv = pv_cnt; b_dn = done_cnt;
    for (int i = 0; i < 16; i++) begin
      start = tv[i].st[0];
      pix_valid = tv[i].vl[0];
      pix_data = 16'(tv[i].dat);
      tick();
      chk($sformatf("v%0d_ready", i), 32'(pix_ready), tv[i].pr);
      chk($sformatf("v%0d_wr_en", i), 32'(wr_en), tv[i].wr);
      chk($sformatf("v%0d_rd_en", i), 32'(rd_en), tv[i].rd);
      chk($sformatf("v%0d_wr_clr", i), 32'(wr_clr), tv[i].clr);
      chk($sformatf("v%0d_busy", i), 32'(busy), tv[i].bsy);
      chk($sformatf("v%0d_col", i), 32'(col_cnt), tv[i].col);
      chk($sformatf("v%0d_row", i), 32'(row_cnt), tv[i].row);
      chk($sformatf("v%0d_done", i), 32'(done), tv[i].dn);
    end
    start = 1'b0;
    feed(0, 10, -1, -1);
    drain_check();
    chk("A_wr_pulses", wr_cnt - b_wr, NPIX);
    chk("A_pv_pulses", pv_cnt - b_pv, EXP_PV);
    chk("A_done_pulses", done_cnt - b_dn, 1);

    // Frame B: random 0-3 cycle stalls plus a stray start mid-row.
    b_wr = wr_cnt; b_pv = pv_cnt; b_dn = done_cnt;
    do_start();
    feed(3, 0, 10, -1);
    drain_check();
    chk("B_wr_pulses", wr_cnt - b_wr, NPIX);
    chk("B_pv_pulses", pv_cnt - b_pv, EXP_PV);
    chk("B_done_pulses", done_cnt - b_dn, 1);

    // Frame C: reset in the middle of row 1 aborts the frame without done.
    b_dn = done_cnt;
    do_start();
    feed(0, 0, -1, 12);
    chk("C_no_done", done_cnt - b_dn, 0);
    chk("C_idle_busy", 32'(busy), 0);

    // Frame D: a complete frame after the abort.
    b_wr = wr_cnt; b_pv = pv_cnt; b_dn = done_cnt;
    do_start();
    feed(0, 0, -1, -1);
    drain_check();
    chk("D_wr_pulses", wr_cnt - b_wr, NPIX);
    chk("D_pv_pulses", pv_cnt - b_pv, EXP_PV);
    chk("D_done_pulses", done_cnt - b_dn, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
